memory_r1_up_seq: RTL and testbench
===================================

Name: memory_r1_up_seq

Overview:
- Serial access sequencer on the issuing side of the r1 upper mercury tank interface.
- Tracks tank circulation with a digit counter and a minor-cycle counter: 18 digit times × 32 minor cycles = 576 clocks, which is 1.152 ms at 2 µs per digit.
- Accepts a parallel short-word read or write request and waits for the addressed minor cycle.
- Drives the tank's r1_mib, t0_in, t0_clr and t0_out gates, and deserialises r1_up_mob_t0 into a parallel result.

Parameters:
- DIGITS, 18, digit times per minor cycle (17 data digits plus 1 gap digit).
- WORD_BITS, 17, short-word width; must be less than DIGITS.
- MINORS, 32, minor cycles per tank circulation.
- ADDR_W, 5, width of minor-cycle address; 2**ADDR_W must equal MINORS.

Ports:
- r1_clk  input  1  digit clock; one rising edge per digit time.
- r1_rst  input  1  asynchronous, active-high reset.
- req  input  1  access request; sampled only in IDLE.
- we  input  1  1 = write, 0 = read; latched with req.
- addr  input  ADDR_W  target minor cycle; latched with req.
- wdata  input  WORD_BITS  write word; latched with req.
- busy  output  1  high from the cycle after acceptance through DONE.
- done  output  1  one-cycle completion pulse.
- rdata  output  WORD_BITS  last word read; holds until the next read completes.
- r1_mib  output  1  serial write data to tank, LSB first.
- r1_up_t0_in  output  1  tank input gate.
- r1_up_t0_clr  output  1  tank recirculation-clear gate.
- r1_up_t0_out  output  1  tank output gate.
- r1_up_mob_t0  input  1  serial data from tank.
- digit  output  5  current digit count, 0..DIGITS-1.
- minor  output  ADDR_W  current minor cycle, 0..MINORS-1.
- tank_sync  output  1  high while digit==0 and minor==0; monitor timing reference.

Behaviour:
- Reset (asynchronous, r1_rst=1):
  - digit=0, minor=0, state=IDLE.
  - busy, done, r1_mib, t0_in, t0_clr, t0_out all 0; rdata=0; latched request cleared.
  - Asserting reset mid-transfer aborts the transfer immediately. No done pulse is produced.
- Counters:
  - digit increments every clock and wraps DIGITS-1 → 0.
  - minor increments when digit wraps and wraps MINORS-1 → 0.
  - Counters run in every state and are never stalled by requests.
- All gate and data outputs are registered, so they are valid during the cycle whose counters they are aligned to.
- States: IDLE, WAIT, XFER, DONE.
- IDLE:
  - req=1 latches we, addr and wdata; next state WAIT; busy=1 from the next cycle.
  - req=0 stays in IDLE.
- WAIT:
  - Transitions to XFER on the edge where counters read digit=DIGITS-1 and minor=(addr-1) mod MINORS.
  - The first XFER cycle therefore coincides with digit=0, minor=addr.
  - If acceptance lands after that boundary edge, WAIT lasts a full revolution; maximum wait is 576 cycles.
  - addr=0 aligns with the wrap from minor=MINORS-1.
- XFER (digits 0..WORD_BITS-1):
  - Write: t0_in=1, t0_clr=1, r1_mib=wdata[digit]; t0_out=0.
  - Read: t0_out=1 and r1_up_mob_t0 is sampled at the end of each cycle into shift position [digit]; t0_in=t0_clr=0, r1_mib=0.
  - Leaves to DONE after digit=WORD_BITS-1.
- DONE (aligned with gap digit, digit=DIGITS-1):
  - All gates=0, done=1, busy=1.
  - On a read, rdata is updated with the assembled word in this cycle.
  - Next state IDLE, with busy=0 and done=0.
- Back-to-back: req held high through DONE is ignored until IDLE. A request accepted in the IDLE cycle right after DONE targeting addr+1 misses that slot and waits 575 cycles.
- Outside XFER: r1_mib=0 and all gates=0.
- Changes to req, we, addr or wdata while busy have no effect.
- Read latency from acceptance to done: 2 + wait + WORD_BITS cycles.

Test Plan:
- Reset release: counters 0, tank_sync=1 at first cycle, all outputs 0. 576 clocks later tank_sync=1 again, with no other pulse in between.
- Write addr=3, wdata=17'h1A5A5 issued at digit=0/minor=0:
  - t0_in=t0_clr=1 for exactly 17 cycles starting at digit=0/minor=3.
  - r1_mib sequence is 1,0,1,0,0,1,0,1,1,0,1,0,0,1,0,1,1 (LSB first).
  - done at digit=17/minor=3.
- Read addr=31, bench drives r1_up_mob_t0 with 17'h0F0F1 serially during minor 31:
  - t0_out high for 17 cycles.
  - rdata=17'h0F0F1 with done at digit=17/minor=31.
- Request for addr=5 accepted in the cycle counters read digit=17/minor=4: boundary missed, transfer starts at digit=0/minor=5 of the next revolution (576 cycles later), done once.
- Assert r1_rst at digit 8 of a write XFER: all gates drop asynchronously, no done pulse, counters at 0, and the next request behaves normally.
- Hold req=1 continuously for back-to-back reads to addr 7: exactly one done per revolution, with busy low for a single IDLE cycle between accesses.

Source files
------------

// File: rtl/memory_r1_up_seq.sv
// Serial access sequencer for the r1 upper mercury tank: tracks circulation
// position and gates one short word in or out at the addressed minor cycle.
module memory_r1_up_seq #(
   parameter int DIGITS    = 18,
   parameter int WORD_BITS = 17,
   parameter int MINORS    = 32,
   parameter int ADDR_W    = 5
) (
   input  logic                 r1_clk,
   input  logic                 r1_rst,
   input  logic                 req,
   input  logic                 we,
   input  logic [ADDR_W-1:0]    addr,
   input  logic [WORD_BITS-1:0] wdata,
   output logic                 busy,
   output logic                 done,
   output logic [WORD_BITS-1:0] rdata,
   output logic                 r1_mib,
   output logic                 r1_up_t0_in,
   output logic                 r1_up_t0_clr,
   output logic                 r1_up_t0_out,
   input  logic                 r1_up_mob_t0,
   output logic [4:0]           digit,
   output logic [ADDR_W-1:0]    minor,
   output logic                 tank_sync
);

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_WAIT = 2'd1;
   localparam logic [1:0] ST_XFER = 2'd2;
   localparam logic [1:0] ST_DONE = 2'd3;

   localparam logic [4:0]        DIGIT_LAST = 5'(DIGITS - 1);
   localparam logic [4:0]        XFER_LAST  = 5'(WORD_BITS - 1);
   localparam logic [ADDR_W-1:0] MINOR_LAST = ADDR_W'(MINORS - 1);

   logic [1:0]           state_reg, state_next;
   logic [4:0]           digit_reg, digit_next;
   logic [ADDR_W-1:0]    minor_reg, minor_next;
   logic                 we_reg;
   logic [ADDR_W-1:0]    addr_reg;
   logic [WORD_BITS-1:0] wsh_reg;
   logic [WORD_BITS-2:0] rsh_reg;
   logic [WORD_BITS-1:0] rdata_reg;
   logic                 busy_reg, done_reg, mib_reg;
   logic                 t0_in_reg, t0_clr_reg, t0_out_reg;
   logic                 digit_wrap, slot_edge, xfer_next, rd_last;

   always_comb begin
      digit_wrap = (digit_reg == DIGIT_LAST);
      digit_next = digit_wrap ? 5'd0 : digit_reg + 5'd1;
      minor_next = minor_reg;
      if (digit_wrap) begin
         minor_next = (minor_reg == MINOR_LAST) ? '0 : minor_reg + ADDR_W'(1);
      end
      // The edge into digit 0 of the target slot; addr 0 wraps to the last minor.
      slot_edge = digit_wrap && (minor_reg == addr_reg - ADDR_W'(1));

      state_next = state_reg;
      case (state_reg)
         ST_IDLE: if (req) state_next = ST_WAIT;
         ST_WAIT: if (slot_edge) state_next = ST_XFER;
         ST_XFER: if (digit_reg == XFER_LAST) state_next = ST_DONE;
         ST_DONE: state_next = ST_IDLE;
         default: state_next = ST_IDLE;
      endcase

      xfer_next = (state_next == ST_XFER);
      rd_last   = (state_reg == ST_XFER) && (state_next == ST_DONE) && !we_reg;
   end

   // Outputs are computed from the next state so they line up with the counters.
   always_ff @(posedge r1_clk or posedge r1_rst) begin
      if (r1_rst) begin
         state_reg  <= ST_IDLE;
         digit_reg  <= '0;
         minor_reg  <= '0;
         we_reg     <= 1'b0;
         addr_reg   <= '0;
         wsh_reg    <= '0;
         rsh_reg    <= '0;
         rdata_reg  <= '0;
         busy_reg   <= 1'b0;
         done_reg   <= 1'b0;
         mib_reg    <= 1'b0;
         t0_in_reg  <= 1'b0;
         t0_clr_reg <= 1'b0;
         t0_out_reg <= 1'b0;
      end else begin
         state_reg  <= state_next;
         digit_reg  <= digit_next;
         minor_reg  <= minor_next;
         busy_reg   <= (state_next != ST_IDLE);
         done_reg   <= (state_next == ST_DONE);
         t0_in_reg  <= xfer_next && we_reg;
         t0_clr_reg <= xfer_next && we_reg;
         t0_out_reg <= xfer_next && !we_reg;
         mib_reg    <= xfer_next && we_reg && wsh_reg[0];

         if (state_reg == ST_IDLE && req) begin
            we_reg   <= we;
            addr_reg <= addr;
            wsh_reg  <= wdata;
         end else if (xfer_next) begin
            wsh_reg <= wsh_reg >> 1;
         end

         // Tank bits arrive LSB first; the final bit is merged straight into rdata.
         if (state_reg == ST_XFER && !we_reg) begin
            rsh_reg <= {r1_up_mob_t0, rsh_reg[WORD_BITS-2:1]};
         end
         if (rd_last) begin
            rdata_reg <= {r1_up_mob_t0, rsh_reg};
         end
      end
   end

   assign busy         = busy_reg;
   assign done         = done_reg;
   assign rdata        = rdata_reg;
   assign r1_mib       = mib_reg;
   assign r1_up_t0_in  = t0_in_reg;
   assign r1_up_t0_clr = t0_clr_reg;
   assign r1_up_t0_out = t0_out_reg;
   assign digit        = digit_reg;
   assign minor        = minor_reg;
   assign tank_sync    = (digit_reg == 5'd0) && (minor_reg == '0);

endmodule

// File: tb/tb_memory_r1_up_seq.sv
// Bench for memory_r1_up_seq: directed tank-timing cases plus random traffic,
// checked every cycle against a timeline model derived from absolute clock count.
module tb_memory_r1_up_seq;

   localparam int DIG = 18;
   localparam int WB  = 17;
   localparam int MIN = 32;
   localparam int REV = DIG * MIN;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        req = 1'b0;
   logic        we = 1'b0;
   logic [4:0]  addr = '0;
   logic [16:0] wdata = '0;
   logic        mob = 1'b0;
   logic        busy, done, r1_mib, t0_in, t0_clr, t0_out, tank_sync;
   logic [16:0] rdata;
   logic [4:0]  digit;
   logic [4:0]  minor;

   memory_r1_up_seq dut (
      .r1_clk       (clk),
      .r1_rst       (rst),
      .req          (req),
      .we           (we),
      .addr         (addr),
      .wdata        (wdata),
      .busy         (busy),
      .done         (done),
      .rdata        (rdata),
      .r1_mib       (r1_mib),
      .r1_up_t0_in  (t0_in),
      .r1_up_t0_clr (t0_clr),
      .r1_up_t0_out (t0_out),
      .r1_up_mob_t0 (mob),
      .digit        (digit),
      .minor        (minor),
      .tank_sync    (tank_sync)
   );

   always #5 clk = ~clk;

   int          checks = 0;
   int          errors = 0;
   int          t = 0;
   bit          have_txn = 1'b0;
   int          ta = 0;
   int          s = 0;
   bit          m_we = 1'b0;
   int          m_addr = 0;
   logic [16:0] m_wdata = '0;
   logic [16:0] m_rword = '0;
   logic [16:0] exp_rdata = '0;
   logic [16:0] rd_word = '0;
   logic [16:0] mib_cap = '0;
   int          in_cnt = 0, out_cnt = 0;
   int          done_cnt = 0, exp_done_cnt = 0;
   int          done_dig = 0, done_min = 0, done_t = 0;
   int          txn_no = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
      checks++;
      assert (obs === exp_v) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h t=%0d", tag, obs, exp_v, t);
      end
   endtask

   // One clock: check cycle t against the timeline, then apply this cycle's inputs.
   task automatic step();
      bit x, dn, bz, wb;
      int k;
      k  = t - s;
      x  = have_txn && t >= s && t <= s + WB - 1;
      dn = have_txn && t == s + WB;
      bz = have_txn && t > ta && t <= s + WB;
      wb = 1'b0;
      if (x && m_we) wb = m_wdata[k];
      if (dn && !m_we) exp_rdata = m_rword;

      chk("digit", digit, t % DIG);
      chk("minor", minor, (t / DIG) % MIN);
      chk("tank_sync", tank_sync, (t % REV) == 0);
      chk("busy", busy, bz);
      chk("done", done, dn);
      chk("t0_in", t0_in, x && m_we);
      chk("t0_clr", t0_clr, x && m_we);
      chk("t0_out", t0_out, x && !m_we);
      chk("mib", r1_mib, wb);
      chk("rdata", rdata, exp_rdata);

      if (t0_in) in_cnt++;
      if (t0_out) out_cnt++;
      if (x) mib_cap[k] = r1_mib;
      if (dn) exp_done_cnt++;
      if (done) begin
         done_cnt++;
         done_dig = digit;
         done_min = minor;
         done_t   = t;
         txn_no++;
         $display("txn %0d: %s addr=%0d accepted t=%0d done t=%0d rdata=%05h",
                  txn_no, m_we ? "write" : "read ", m_addr, ta, t, rdata);
      end

      if (req && (!have_txn || t >= s + WB + 1)) begin
         have_txn = 1'b1;
         ta       = t;
         m_we     = we;
         m_addr   = addr;
         m_wdata  = wdata;
         m_rword  = rd_word;
         s        = ta + 2 + ((m_addr * DIG - (ta + 2) % REV + REV) % REV);
         in_cnt   = 0;
         out_cnt  = 0;
         mib_cap  = '0;
      end
      if (have_txn && !m_we && t >= s && t <= s + WB - 1) mob = m_rword[t - s];
      else mob = 1'($urandom_range(0, 1));

      @(posedge clk);
      #1;
      t++;
   endtask

   task automatic run(input int n);
      repeat (n) step();
   endtask

   task automatic wait_idle(input int limit);
      int c = 0;
      while (have_txn && t < s + WB + 1 && c < limit) begin
         step();
         c++;
      end
      chk("idle_bound", c < limit, 1);
   endtask

   task automatic issue(input bit w, input int a, input logic [16:0] d);
      req   = 1'b1;
      we    = w;
      addr  = 5'(a);
      wdata = d;
      step();
      req   = 1'b0;
      we    = 1'($urandom);
      addr  = 5'($urandom);
      wdata = 17'($urandom);
   endtask

   initial begin
      int c, b0, e0;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_digit", digit, 0);
      chk("rst_minor", minor, 0);
      chk("rst_sync", tank_sync, 1);
      chk("rst_busy", busy, 0);
      chk("rst_gates", {r1_mib, t0_in, t0_clr, t0_out, done}, 0);
      chk("rst_rdata", rdata, 0);
      rst = 1'b0;
      t   = 0;

      // One full revolution idle: tank_sync only at t=0 and t=576.
      run(REV);

      issue(1'b1, 3, 17'h1A5A5);
      wait_idle(1200);
      chk("w3_in_cnt", in_cnt, 17);
      chk("w3_mib_seq", mib_cap, 17'h1A5A5);
      chk("w3_done_dig", done_dig, 17);
      chk("w3_done_min", done_min, 3);

      rd_word = 17'h0F0F1;
      issue(1'b0, 31, 17'($urandom));
      wait_idle(1200);
      chk("r31_out_cnt", out_cnt, 17);
      chk("r31_rdata", rdata, 17'h0F0F1);
      chk("r31_done_dig", done_dig, 17);
      chk("r31_done_min", done_min, 31);

      // Accept exactly at digit 17 / minor 4 so the addr-5 slot is missed.
      c = 0;
      while ((t % REV) != (4 * DIG + 17) && c < 700) begin
         step();
         c++;
      end
      chk("a5_align_bound", c < 700, 1);
      b0 = done_cnt;
      issue(1'b1, 5, 17'($urandom));
      wait_idle(1200);
      chk("a5_done_t", done_t - ta, 577 + WB);
      chk("a5_done_min", done_min, 5);
      chk("a5_done_once", done_cnt - b0, 1);

      // Reset during digit 8 of a write transfer.
      issue(1'b1, $urandom_range(0, 31), 17'($urandom));
      c = 0;
      while (t < s + 8 && c < 1200) begin
         step();
         c++;
      end
      chk("mid_bound", c < 1200, 1);
      chk("pre_rst_in", t0_in, 1);
      chk("pre_rst_digit", digit, 8);
      b0 = done_cnt;
      rst = 1'b1;
      #1;
      chk("mid_rst_gates", {r1_mib, t0_in, t0_clr, t0_out}, 0);
      chk("mid_rst_done", done, 0);
      chk("mid_rst_busy", busy, 0);
      chk("mid_rst_cnt", {digit, minor}, 0);
      @(posedge clk);
      #1;
      chk("mid_rst_hold", {digit, minor, done}, 0);
      rst       = 1'b0;
      t         = 0;
      have_txn  = 1'b0;
      exp_rdata = '0;
      rd_word   = 17'($urandom);
      issue(1'b0, 2, 17'($urandom));
      wait_idle(1200);
      chk("post_rst_rdata", rdata, rd_word);
      chk("post_rst_done", done_cnt - b0, 1);

      // Back-to-back reads to addr 7 with req held high.
      b0 = done_cnt;
      e0 = exp_done_cnt;
      rd_word = 17'($urandom);
      req  = 1'b1;
      we   = 1'b0;
      addr = 5'd7;
      run(3 * REV);
      req = 1'b0;
      wait_idle(1200);
      chk("b2b_dones", done_cnt - b0, exp_done_cnt - e0);
      chk("b2b_min_dones", (done_cnt - b0) >= 3, 1);

      // Random traffic, inputs churning every cycle including while busy.
      repeat (3000) begin
         req     = ($urandom_range(0, 7) == 0);
         we      = 1'($urandom);
         addr    = 5'($urandom);
         wdata   = 17'($urandom);
         rd_word = 17'($urandom);
         step();
      end
      req = 1'b0;
      wait_idle(1200);
      chk("rand_dones", done_cnt, exp_done_cnt);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
